key_expansion_ctrl: RTL
=======================

// Module: key_expansion_ctrl
// PURPOSE
//  Sequencer for the byte-serial AES-128 key expansion datapath (16-byte shift ring, one S-box, rcon XOR).
//  Loads the 16 cipher-key bytes, then drives the per-byte mux selects, rcon gating and round index for
//  rounds 1..10 (16 clk each), and flags each round-key byte for the cipher datapath. Sits beside the
//  state-datapath controller in the top level and is started once per new key.
// PARAMETERS
//  NROUNDS   10  number of round keys generated after load (AES-128)
//  NBYTES    16  bytes per round key / shift-ring depth
// PORTS
//  clk           in   1  system clock, all state on posedge
//  rst           in   1  synchronous, active-high reset
//  start         in   1  begin load+expand; sampled only when ready=1
//  abort         in   1  return to IDLE at next edge, no done pulse
//  ready         out  1  high in IDLE
//  key_req       out  1  high on the 16 LOAD cycles; upstream presents key byte key_idx that cycle
//  key_idx       out  4  index 0..15 of key byte requested (MSB-first, byte 0 = key[127:120])
//  input_sel     out  1  1 = shift ring takes external key byte; 0 = takes recirculated round-key byte
//  sbox_sel      out  1  0 = S-box fed from ring tap; 1 = fed from held (rotated) byte
//  last_out_sel  out  1  1 = ring output XORed with S-box/rcon result; 0 = pass-through
//  bit_out_sel   out  1  1 = word-chain XOR into feedback stage; 0 = pass-through
//  rcon_en       out  8  8'hFF enables rcon XOR (and captures rotate byte); 8'h00 otherwise
//  round_cnt     out  4  rcon index for current round (0..9)
//  rk_valid      out  1  rk byte on datapath output is a valid round-key byte this cycle
//  rk_round      out  4  round number of the valid byte (1..10)
//  rk_byte       out  4  byte index 0..15 of the valid byte
//  busy          out  1  high in LOAD and EXPAND
//  done          out  1  one-cycle pulse after last byte of round NROUNDS
// BEHAVIOUR
//  States: IDLE -> LOAD (16 clk) -> EXPAND (NROUNDS*16 clk) -> DONE (1 clk) -> IDLE.
//  Counters: byte_cnt 4b (0..15, wraps), rnd_cnt 4b (0..NROUNDS-1). Both cleared on entering LOAD.
//  IDLE: ready=1; all selects 0, rcon_en=0, key_req=0. start=1 -> LOAD next cycle.
//  LOAD: input_sel=1, key_req=1, key_idx=byte_cnt; other selects 0; rk_valid=0. At byte_cnt=15 -> EXPAND.
//  EXPAND, per byte_cnt b (outputs registered, valid in the cycle b is shown):
//   input_sel=0 all b.
//   last_out_sel=1 for b=0..3 (first word gets SubWord(RotWord)), else 0.
//   sbox_sel=0 for b=0..2, 1 for b=3 (rotation wrap uses held byte).
//   rcon_en=8'hFF only at b=0 (rcon applied to first byte; held byte captured), else 8'h00.
//   bit_out_sel=1 for b=4..15 (w[i]=w[i-1]^w[i-4]), 0 for b=0..3.
//   round_cnt=rnd_cnt; rk_valid=1; rk_round=rnd_cnt+1; rk_byte=b.
//   b=15: rnd_cnt++; if rnd_cnt=NROUNDS-1 -> DONE.
//  DONE: done=1 one cycle, busy=0, rk_valid=0, then IDLE. Last rk_valid is the cycle before done.
//  Latency: start edge -> first key_req 1 clk; round-1 byte 0 valid 17 clk after start accepted;
//   done at start+1+16+160 clk.
//  start while busy: ignored. abort: from any non-IDLE state, IDLE next edge, counters cleared, no done;
//   abort and start together in IDLE: start wins (abort is no-op in IDLE).
//  rst: all outputs 0 except ready=1 in IDLE; mid-operation reset discards progress identically.
//  round_cnt never exceeds NROUNDS-1; outside EXPAND it is 0.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start -> rk_round1 bytes a0fafe1788542cb123a339392a6c7605,
//    round10 d014f9a8c9ee2589e13f0cc8b6630ca6; done exactly 177 clk after start.
//  2 Select trace: every EXPAND round, rcon_en=FF only at b=0, sbox_sel=1 only b=3, last_out_sel b=0..3,
//    bit_out_sel b=4..15; round_cnt steps 0..9.
//  3 start asserted during LOAD and EXPAND -> ignored; single done; output stream unchanged.
//  4 abort at round 5 byte 7 -> IDLE next clk, rk_valid=0, no done; new start with all-zero key ->
//    round1 62636363626363636263636362636363.
//  5 rst mid-EXPAND -> next cycle ready=1, all selects/rcon_en 0, round_cnt=0; restart gives test-1 result.
//  6 Back-to-back: start on the cycle after done -> second key processed with identical timing.

Source files
------------

// File: rtl/key_expansion_ctrl.sv
// Sequencer for the byte-serial AES-128 key expansion datapath: loads the cipher key,
// then steps the ring/S-box/rcon selects through NROUNDS rounds of NBYTES bytes each.
module key_expansion_ctrl #(
  parameter int NROUNDS = 10,
  parameter int NBYTES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       ready,
  output logic       key_req,
  output logic [3:0] key_idx,
  output logic       input_sel,
  output logic       sbox_sel,
  output logic       last_out_sel,
  output logic       bit_out_sel,
  output logic [7:0] rcon_en,
  output logic [3:0] round_cnt,
  output logic       rk_valid,
  output logic [3:0] rk_round,
  output logic [3:0] rk_byte,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  // Handshake: start is a request accepted on the edge where ready=1 and start=1;
  // ready drops the following cycle and returns only once the sequence ends or is aborted.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic       key_req;
    logic [3:0] key_idx;
    logic       input_sel;
    logic       sbox_sel;
    logic       last_out_sel;
    logic       bit_out_sel;
    logic [7:0] rcon_en;
    logic [3:0] round_cnt;
    logic       rk_valid;
    logic [3:0] rk_round;
    logic [3:0] rk_byte;
    logic       busy;
    logic       done;
    logic       ready;
  } outs_t;

  localparam logic [3:0] LAST_BYTE = 4'(NBYTES - 1);
  localparam logic [3:0] LAST_RND  = 4'(NROUNDS - 1);

  state_t     state;
  logic [3:0] byte_cnt;
  logic [3:0] rnd_cnt;
  outs_t      o;

  function automatic outs_t idle_outs();
    outs_t v;
    v       = '0;
    v.ready = 1'b1;
    return v;
  endfunction

  function automatic outs_t load_outs(input logic [3:0] b);
    outs_t v;
    v           = '0;
    v.key_req   = 1'b1;
    v.key_idx   = b;
    v.input_sel = 1'b1;
    v.busy      = 1'b1;
    return v;
  endfunction

  // First word of each round takes SubWord(RotWord) with rcon on byte 0; the held
  // byte captured at b=0 closes the rotation at b=3; later words chain w[i-1]^w[i-4].
  function automatic outs_t expand_outs(input logic [3:0] b, input logic [3:0] r);
    outs_t v;
    v              = '0;
    v.last_out_sel = (b < 4'd4);
    v.sbox_sel     = (b == 4'd3);
    v.rcon_en      = (b == 4'd0) ? 8'hFF : 8'h00;
    v.bit_out_sel  = (b >= 4'd4);
    v.round_cnt    = r;
    v.rk_valid     = 1'b1;
    v.rk_round     = r + 4'd1;
    v.rk_byte      = b;
    v.busy         = 1'b1;
    return v;
  endfunction

  function automatic outs_t done_outs();
    outs_t v;
    v      = '0;
    v.done = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= 4'd0;
      rnd_cnt  <= 4'd0;
      o        <= idle_outs();
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            byte_cnt <= 4'd0;
            rnd_cnt  <= 4'd0;
            o        <= load_outs(4'd0);
          end else begin
            o <= idle_outs();
          end
        end
        S_LOAD: begin
          if (abort) begin
            state    <= S_IDLE;
            byte_cnt <= 4'd0;
            rnd_cnt  <= 4'd0;
            o        <= idle_outs();
          end else if (byte_cnt == LAST_BYTE) begin
            state    <= S_EXPAND;
            byte_cnt <= 4'd0;
            rnd_cnt  <= 4'd0;
            o        <= expand_outs(4'd0, 4'd0);
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
            o        <= load_outs(byte_cnt + 4'd1);
          end
        end
        S_EXPAND: begin
          if (abort) begin
            state    <= S_IDLE;
            byte_cnt <= 4'd0;
            rnd_cnt  <= 4'd0;
            o        <= idle_outs();
          end else if (byte_cnt == LAST_BYTE) begin
            byte_cnt <= 4'd0;
            if (rnd_cnt == LAST_RND) begin
              state   <= S_DONE;
              rnd_cnt <= 4'd0;
              o       <= done_outs();
            end else begin
              rnd_cnt <= rnd_cnt + 4'd1;
              o       <= expand_outs(4'd0, rnd_cnt + 4'd1);
            end
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
            o        <= expand_outs(byte_cnt + 4'd1, rnd_cnt);
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          byte_cnt <= 4'd0;
          rnd_cnt  <= 4'd0;
          o        <= idle_outs();
        end
        default: begin
          state    <= S_IDLE;
          byte_cnt <= 4'd0;
          rnd_cnt  <= 4'd0;
          o        <= idle_outs();
        end
      endcase
    end
  end

  assign ready        = o.ready;
  assign key_req      = o.key_req;
  assign key_idx      = o.key_idx;
  assign input_sel    = o.input_sel;
  assign sbox_sel     = o.sbox_sel;
  assign last_out_sel = o.last_out_sel;
  assign bit_out_sel  = o.bit_out_sel;
  assign rcon_en      = o.rcon_en;
  assign round_cnt    = o.round_cnt;
  assign rk_valid     = o.rk_valid;
  assign rk_round     = o.rk_round;
  assign rk_byte      = o.rk_byte;
  assign busy         = o.busy;
  assign done         = o.done;
  assign dbg_state    = state;

endmodule
